// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer: FSM encoding, frame size,
// and the helper that packs a command into its 16-bit transmit frame.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      DONE
   } state_t;

   localparam int   FRAME_BITS = 16;
   localparam logic RW_READ    = 1'b1;
   localparam logic RW_WRITE   = 1'b0;

   // Reads send a zero data byte so the slave's reply owns the low half.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] addr,
                                                        input logic       rw,
                                                        input logic [7:0] wdata);
      return {addr, rw, (rw == RW_READ) ? 8'h00 : wdata};
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command handshake plus SPI pin bundle for spi_master_ctrl.
// The master modport is the controller's view; slave is the user/peripheral view.
interface spi_master_ctrl_if;

   logic       start;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       miso_cond;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       sclk;
   logic       cs;
   logic       mosi;

   modport master (
      input  start, rw, addr, wdata, miso_cond,
      output busy, done, rdata, sclk, cs, mosi
   );

   modport slave (
      output start, rw, addr, wdata, miso_cond,
      input  busy, done, rdata, sclk, cs, mosi
   );

endinterface

// File: rtl/spi_sclk_div.sv
// Half-period tick generator: while enabled, emits a registered one-cycle tick
// every CLKDIV clocks; disabling it clears the phase so each frame starts aligned.
module spi_sclk_div #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

   logic [CW-1:0] cnt_reg;
   logic          tick_reg;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         tick_reg <= (cnt_reg == LAST);
         cnt_reg  <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
      end
   end

   assign tick = tick_reg;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 transaction sequencer: one 16-bit frame per accepted command,
// MSB first, capturing the slave's byte from the last eight sclk rises.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLKDIV = 4
) (
   input logic               clk,
   input logic               reset,
   spi_master_ctrl_if.master bus
);

   state_t                state_reg;
   logic [FRAME_BITS-1:0] tx_reg;
   logic [7:0]            rx_reg;
   logic [7:0]            rdata_reg;
   logic [4:0]            hp_reg;
   logic                  rw_reg;
   logic                  sclk_reg;
   logic                  cs_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  div_en;
   logic                  tick;

   assign div_en = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD);

   spi_sclk_div #(.CLKDIV(CLKDIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (div_en),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         tx_reg    <= '0;
         rx_reg    <= '0;
         rdata_reg <= '0;
         hp_reg    <= '0;
         rw_reg    <= RW_WRITE;
         sclk_reg  <= 1'b0;
         cs_reg    <= 1'b1;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  tx_reg    <= build_frame(bus.addr, bus.rw, bus.wdata);
                  rw_reg    <= bus.rw;
                  hp_reg    <= '0;
                  cs_reg    <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               // The tick ending setup is also the first rising sclk edge.
               if (tick) begin
                  sclk_reg  <= 1'b1;
                  rx_reg    <= {rx_reg[6:0], bus.miso_cond};
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (hp_reg == 5'd31) begin
                     state_reg <= HOLD;
                  end else begin
                     hp_reg   <= hp_reg + 5'd1;
                     sclk_reg <= ~sclk_reg;
                     if (!sclk_reg) begin
                        rx_reg <= {rx_reg[6:0], bus.miso_cond};
                     end else if (hp_reg != 5'd30) begin
                        tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
                     end
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  cs_reg    <= 1'b1;
                  done_reg  <= 1'b1;
                  tx_reg    <= '0;
                  state_reg <= DONE;
                  if (rw_reg == RW_READ) begin
                     rdata_reg <= rx_reg;
                  end
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;
   assign bus.rdata = rdata_reg;
   assign bus.sclk  = sclk_reg;
   assign bus.cs    = cs_reg;
   assign bus.mosi  = tx_reg[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (CLKDIV=4) with a small SPI slave monitor
// that collects mosi at sclk rises and serves a read byte on miso.
module tb_spi_master_ctrl;

   localparam int CLKDIV    = 4;
   localparam int RISE_LAT  = CLKDIV + 1;
   localparam int DONE_LAT  = 34 * CLKDIV + 1;
   localparam int FRAME_GAP = DONE_LAT + 2;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   int tests_run    = 0;
   int tests_failed = 0;

   spi_master_ctrl_if bus ();

   spi_master_ctrl #(.CLKDIV(CLKDIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave/monitor state, written only by the monitor process.
   logic [7:0]  slave_byte = 8'h00;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   int          rise_cnt = 0;
   int          last_rises = 0;
   logic [15:0] mosi_shift = '0;
   logic [15:0] last_mosi = '0;
   int          first_rise_cyc = 0;
   int          cs_hi_run = 0;
   int          last_cs_hi = 0;
   int          done_cnt = 0;
   int          last_done_cyc = 0;
   int          done_gap = 0;
   logic [7:0]  done_rdata = '0;
   int          accept_cyc = 0;

   always @(negedge clk) begin
      if (bus.cs === 1'b0 && prev_cs === 1'b1) begin
         rise_cnt   = 0;
         mosi_shift = '0;
         last_cs_hi = cs_hi_run;
         cs_hi_run  = 0;
      end
      if (bus.cs === 1'b1) cs_hi_run++;
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0 && bus.cs === 1'b0) begin
         rise_cnt++;
         mosi_shift = {mosi_shift[14:0], bus.mosi};
         if (rise_cnt == 1) first_rise_cyc = cyc;
      end
      if (bus.cs === 1'b1 && prev_cs === 1'b0) begin
         last_rises = rise_cnt;
         last_mosi  = mosi_shift;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_gap      = cyc - last_done_cyc;
         last_done_cyc = cyc;
         done_rdata    = bus.rdata;
      end
      if (bus.cs !== 1'b0)
         bus.miso_cond = 1'b0;
      else if (bus.sclk === 1'b0)
         bus.miso_cond = (rise_cnt >= 8 && rise_cnt < 16) ? slave_byte[3'(15 - rise_cnt)] : 1'b0;
      prev_cs   = bus.cs;
      prev_sclk = bus.sclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_frame(input logic [6:0] a, input logic r, input logic [7:0] w, input logic hold);
      bus.addr   = a;
      bus.rw     = r;
      bus.wdata  = w;
      bus.start  = 1'b1;
      accept_cyc = cyc + 1;
      tick();
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < 400) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt - base), 32'd1);
   endtask

   task automatic frame_checks(input string tag, input logic [15:0] exp_frame, input logic [7:0] exp_rdata);
      check({tag, "_mosi"},    32'(last_mosi), 32'(exp_frame));
      check({tag, "_rises"},   32'(last_rises), 32'd16);
      check({tag, "_done_lat"}, 32'(last_done_cyc - accept_cyc), 32'(DONE_LAT));
      check({tag, "_rdata"},   32'(done_rdata), 32'(exp_rdata));
   endtask

   initial begin
      int base;
      int n;
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.rw        = 1'b0;
      bus.addr      = '0;
      bus.wdata     = '0;
      ticks(3);
      reset = 1'b0;
      tick();

      check("rst_cs",    32'(bus.cs),    32'd1);
      check("rst_sclk",  32'(bus.sclk),  32'd0);
      check("rst_mosi",  32'(bus.mosi),  32'd0);
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      ticks(3);

      // Write 0x2A <- 0xC3: frame 16'h54C3, rdata untouched.
      start_frame(7'h2A, 1'b0, 8'hC3, 1'b0);
      check("wr_cs_low", 32'(bus.cs),   32'd0);
      check("wr_busy",   32'(bus.busy), 32'd1);
      wait_done("wr");
      check("wr_rise_lat", 32'(first_rise_cyc - accept_cyc), 32'(RISE_LAT));
      frame_checks("wr", 16'h54C3, 8'h00);
      $display("[TB] write addr=2a wdata=c3 mosi=%h rdata=%h", last_mosi, done_rdata);
      ticks(5);

      // Read 0x05, slave returns 0xA5.
      slave_byte = 8'hA5;
      start_frame(7'h05, 1'b1, 8'hEE, 1'b0);
      wait_done("rd");
      frame_checks("rd", 16'h0B00, 8'hA5);
      check("rd_done_pulse", 32'(bus.done), 32'd1);
      $display("[TB] read  addr=05 mosi=%h rdata=%h", last_mosi, done_rdata);
      tick();
      check("rd_done_1cyc", 32'(bus.done), 32'd0);
      ticks(4);

      // Stray start mid-frame with other operands must be ignored.
      base = done_cnt;
      start_frame(7'h11, 1'b0, 8'h5A, 1'b0);
      ticks(19);
      bus.addr  = 7'h7F;
      bus.rw    = 1'b1;
      bus.wdata = 8'hFF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done("mid");
      frame_checks("mid", 16'h225A, 8'hA5);
      ticks(150);
      check("mid_one_done", 32'(done_cnt - base), 32'd1);
      check("mid_idle",     32'(bus.busy),        32'd0);
      $display("[TB] stray start mosi=%h dones=%0d", last_mosi, done_cnt - base);

      // Reset after the 8th sclk rise aborts without a done pulse.
      slave_byte = 8'h3C;
      base = done_cnt;
      start_frame(7'h33, 1'b1, 8'h00, 1'b0);
      n = 0;
      while (rise_cnt < 8 && n < 200) begin
         tick();
         n++;
      end
      check("abort_reached_rise8", 32'(rise_cnt >= 8), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_cs",    32'(bus.cs),    32'd1);
      check("abort_sclk",  32'(bus.sclk),  32'd0);
      check("abort_busy",  32'(bus.busy),  32'd0);
      check("abort_mosi",  32'(bus.mosi),  32'd0);
      check("abort_rdata", 32'(bus.rdata), 32'd0);
      ticks(150);
      check("abort_no_done", 32'(done_cnt - base), 32'd0);
      slave_byte = 8'h96;
      start_frame(7'h40, 1'b1, 8'h00, 1'b0);
      wait_done("post");
      frame_checks("post", 16'h8100, 8'h96);
      $display("[TB] reset abort then read mosi=%h rdata=%h", last_mosi, done_rdata);
      ticks(5);

      // Back-to-back with start held high.
      start_frame(7'h7E, 1'b0, 8'h81, 1'b1);
      wait_done("b2b0");
      frame_checks("b2b0", 16'hFC81, 8'h96);
      wait_done("b2b1");
      bus.start = 1'b0;
      check("b2b1_mosi",  32'(last_mosi),  32'hFC81);
      check("b2b1_rises", 32'(last_rises), 32'd16);
      check("b2b_gap",    32'(done_gap),   32'(FRAME_GAP));
      check("b2b_cs_hi",  32'(last_cs_hi), 32'd2);
      ticks(5);
      check("b2b_stop", 32'(bus.busy), 32'd0);
      $display("[TB] back-to-back gap=%0d cs_high=%0d", done_gap, last_cs_hi);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
